// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared widths, memory depth and FSM state encoding for ram_stream_reader.
package ram_stream_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH = 32;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/ram32x4_2port.sv
// ram32x4_2port: 32x4 two-port RAM, synchronous write port and combinational read port.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr read address; o_rdata read data.
module ram32x4_2port
  import ram_stream_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of words from a RAM read port and streams them out
// through a one-entry registered valid/ready stage.
// Ports:
//   clk, reset (sync, active-low)
//   start, start_addr, count   burst request, accepted only in IDLE; count saturates to 32
//   addr_r, data_r             RAM read port (combinational read data)
//   out_data, out_valid, out_ready  output stream
//   busy (READ or DRAIN), done (one-cycle completion pulse)
//   checksum                   XOR of words handed out this burst, only with
//                              RAM_STREAM_READER_CHECKSUM_EN defined
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int ADDR_W = ram_stream_pkg::ADDR_W,
  parameter int DATA_W = ram_stream_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addr_r,
  input  logic [DATA_W-1:0] data_r,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef RAM_STREAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(DEPTH);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0] r_rem, w_cnt;
  logic [DATA_W-1:0] r_data;
  logic r_valid, w_start, w_issue, w_take;
  assign w_cnt = (count > MAX_CNT) ? MAX_CNT : count;
  assign w_start = (r_state == IDLE) && start;
  // A new word may enter the output register when it is empty or being drained this cycle.
  assign w_issue = (r_state == READ) && (r_rem != '0) && (!r_valid || out_ready);
  assign w_take = r_valid && out_ready;
  assign addr_r = r_ptr;
  assign out_data = r_data;
  assign out_valid = r_valid;
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      IDLE: w_next = !start ? IDLE : (w_cnt == '0) ? DONE : READ;
      READ: begin
        busy = 1'b1;
        w_next = (w_issue && r_rem == (ADDR_W+1)'(1)) ? DRAIN : READ;
      end
      DRAIN: begin
        busy = 1'b1;
        w_next = w_take ? DONE : DRAIN;
      end
      default: begin
        done = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  // The pointer wraps naturally at the top of the ADDR_W-bit address space.
  always_ff @(posedge clk)
    if (!reset) begin
      r_ptr <= '0;
      r_rem <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_start && w_cnt != '0) begin
        r_ptr <= start_addr;
        r_rem <= w_cnt;
      end
      if (w_issue) begin
        r_data <= data_r;
        r_ptr <= r_ptr + ADDR_W'(1);
        r_rem <= r_rem - (ADDR_W+1)'(1);
      end
      r_valid <= w_issue || (r_valid && !w_take);
    end
`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  assign checksum = r_csum;
  always_ff @(posedge clk)
    if (!reset) r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_take) r_csum <= r_csum ^ r_data;
`endif
endmodule
